// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, display-active flag, delayed active-low
// hsync/vsync and line/frame strobes for a 640x480@60 Hz scan on vga_clk.
// Optional feature macro: VGA_FRAME_CNT_EN adds a 16-bit frame_count output
// that counts frame_start pulses and wraps 65535 -> 0.
// SYNC_DELAY is legal from 0 to 4; 0 makes hs/vs a combinational passthrough.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        sync,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_L    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_L    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] hcount_r;
  logic [9:0] vcount_r;
  logic       hs_raw_s;
  logic       vs_raw_s;

  // Raster position: hcount sweeps each line, vcount advances at line end.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hcount_r <= 10'd0;
      vcount_r <= 10'd0;
    end else if (hcount_r == H_LAST) begin
      hcount_r <= 10'd0;
      if (vcount_r == V_LAST) begin
        vcount_r <= 10'd0;
      end else begin
        vcount_r <= vcount_r + 10'd1;
      end
    end else begin
      hcount_r <= hcount_r + 10'd1;
    end
  end

  // Position outputs and strobes are taken straight from the counters.
  assign DrawX       = hcount_r;
  assign DrawY       = vcount_r;
  assign blank       = (hcount_r < H_VIS_L) && (vcount_r < V_VIS_L);
  assign line_start  = (hcount_r == 10'd0);
  assign frame_start = (hcount_r == 10'd0) && (vcount_r == V_VIS_L);
  assign sync        = 1'b0;

  // vcount only moves when hcount wraps to 0, so vs_raw changes only there.
  assign hs_raw_s = !((hcount_r >= HS_START) && (hcount_r < HS_END));
  assign vs_raw_s = !((vcount_r >= VS_START) && (vcount_r < VS_END));

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign hs = hs_raw_s;
      assign vs = vs_raw_s;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_pipe_r;
      logic [SYNC_DELAY-1:0] vs_pipe_r;

      // Sync delay line keeps hs/vs aligned with the renderers' registered colour.
      always_ff @(posedge vga_clk) begin
        if (reset) begin
          hs_pipe_r <= {SYNC_DELAY{1'b1}};
          vs_pipe_r <= {SYNC_DELAY{1'b1}};
        end else begin
          hs_pipe_r[0] <= hs_raw_s;
          vs_pipe_r[0] <= vs_raw_s;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_pipe_r[i] <= hs_pipe_r[i-1];
            vs_pipe_r[i] <= vs_pipe_r[i-1];
          end
        end
      end

      assign hs = hs_pipe_r[SYNC_DELAY-1];
      assign vs = vs_pipe_r[SYNC_DELAY-1];
    end
  endgenerate

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_count_r;

  // Frames completed: bumps on the frame_start cycle, wraps naturally at 16 bits.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frame_count_r <= 16'd0;
    end else if (frame_start) begin
      frame_count_r <= frame_count_r + 16'd1;
    end else begin
      frame_count_r <= frame_count_r;
    end
  end

  assign frame_count = frame_count_r;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the raster scan consumed by every sprite/screen renderer in the design: DrawX, DrawY, blank (display-active), hs, vs.
- Runs in the vga_clk domain at 25 MHz for 640x480@60 Hz.
- Renderers read ROM on negedge and register colour one posedge later. hs/vs are therefore delayed by a configurable number of cycles so sync stays aligned with renderer colour output.
- Also provides frame/line strobes for game logic (animation ticks, state updates).

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_DELAY, 1, cycles hs/vs lag DrawX/DrawY/blank; legal 0..4

Ports:
- vga_clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1
- DrawY  out  10  current vertical count, 0..V_TOTAL-1
- blank  out  1  1 = visible region (DrawX<H_VISIBLE && DrawY<V_VISIBLE), 0 = blanking
- hs  out  1  horizontal sync, active-low, delayed SYNC_DELAY cycles
- vs  out  1  vertical sync, active-low, delayed SYNC_DELAY cycles
- sync  out  1  composite sync for DAC; tied 0
- line_start  out  1  one-cycle pulse when DrawX==0
- frame_start  out  1  one-cycle pulse when DrawX==0 && DrawY==V_VISIBLE (first blanking line)
- frame_count  out  16  frames completed; present only with VGA_FRAME_CNT_EN

Behaviour:
- Derived constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- The hcount/vcount registers are DrawX/DrawY directly. DrawX, DrawY, blank, line_start and frame_start are combinational from those registers: zero latency.
- Counter update each posedge:
  - If hcount==H_TOTAL-1: hcount<=0. Then if vcount==V_TOTAL-1, vcount<=0; else vcount<=vcount+1.
  - Otherwise hcount<=hcount+1; vcount holds.
- Raw syncs:
  - hs_raw=0 iff H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - vs_raw=0 iff V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC, i.e. lines 490..491.
  - vs changes only at hcount==0 boundaries.
- Delay: hs/vs pass through a SYNC_DELAY-deep shift register, all stages registered. SYNC_DELAY=0 means combinational passthrough.
- Reset (synchronous, checked each posedge, overrides counting):
  - hcount=0, vcount=0, so DrawX=0, DrawY=0, blank=1, line_start=1.
  - Every sync delay stage = 1, so hs=vs=1.
  - frame_count=0.
  - Reset asserted mid-line or mid-vsync forces the above on the next edge. The first post-reset pixel is (0,0).
  - No partial-frame strobe is emitted on reset.
- Wrap: (799,524) -> (0,0) in one cycle. vs is never asserted across the wrap.
- frame_start fires once per frame at (0,480), 420,000 clocks apart.
- Widths: 10-bit counters cover 800/525; no overflow is possible with default parameters.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined:
  - frame_count port exists.
  - Increments by 1 on the posedge where frame_start is high.
  - Wraps 65535->0.
  - Resets to 0.
- Undefined: frame_count port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset held 3 cycles, then released: DrawX=0, DrawY=0, blank=1, hs=1, vs=1 during reset. First posedge after release gives DrawX=1.
- Run one full line: blank 1 for DrawX 0..639, 0 for 640..799. With SYNC_DELAY=1, hs=0 for exactly 96 cycles, on the cycles where DrawX is 657..752 (i.e. one cycle after 656..751). line_start pulses once per 800 clocks.
- Run one full frame: vs low for exactly 2×800 = 1600 clocks, starting one cycle after (0,490). frame_start high only at (0,480). Wrap from (799,524) to (0,0).
- Assert reset at (700,491), mid-hsync and mid-vsync: next cycle DrawX=0, DrawY=0, hs=1, vs=1. No frame_start pulse.
- Compile with VGA_FRAME_CNT_EN and run 3 frames from reset: frame_count goes 0 -> 1 -> 2 -> 3, each increment on the frame_start cycle. Preload to 65535 via a forced counter: next frame_start gives 0.
- Compile with SYNC_DELAY=0: hs falls on the same cycle DrawX becomes 656. With SYNC_DELAY=3: hs falls when DrawX=659.
